// File: rtl/ifu_fetch.sv
// Purpose:      instruction fetch stage; holds the architectural PC and fetches one word per instruction cycle.
// Latency:      2 cycles from REQ to out_valid with zero-wait memory; at least 4 cycles per instruction.
// Backpressure: every channel is valid/ready; araddr and the decode payload are held until their handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_ar*/imem_r*         AXI-lite-style read address / read data channel to instruction memory
//   out_*                    {instr, pc, fault} towards decode, valid/ready
//   pc_valid/pc_ready/pc_next next PC from writeback, valid/ready
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_arvalid,
    input  logic              imem_arready,
    output logic [ADDR_W-1:0] imem_araddr,
    input  logic              imem_rvalid,
    output logic              imem_rready,
    input  logic [31:0]       imem_rdata,
    input  logic [1:0]        imem_rresp,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault,

    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic [ADDR_W-1:0] pc_next
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_RESP   = 2'd1,
        S_OUT    = 2'd2,
        S_WAITPC = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr_q;
    logic              fault_q;

    // One state register drives every handshake output, so at most one of
    // arvalid / rready / out_valid / pc_ready can be high, and each strobe is
    // naturally ignored outside its own state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            instr_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_arready) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        // A faulting response never leaks its data towards decode.
                        instr_q <= (imem_rresp == 2'b00) ? imem_rdata : 32'h0000_0000;
                        fault_q <= (imem_rresp != 2'b00);
                        state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_WAITPC;
                    end
                end
                S_WAITPC: begin
                    if (pc_valid) begin
                        pc <= pc_next;
                        if (pc_next[1:0] != 2'b00) begin
                            // Misaligned target: report the fault without touching the bus.
                            instr_q <= 32'h0000_0000;
                            fault_q <= 1'b1;
                            state   <= S_OUT;
                        end else begin
                            fault_q <= 1'b0;
                            state   <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    assign imem_arvalid = (state == S_REQ);
    assign imem_araddr  = pc;
    assign imem_rready  = (state == S_RESP);

    assign out_valid    = (state == S_OUT);
    assign out_instr    = instr_q;
    assign out_pc       = pc;
    assign out_fault    = fault_q;

    assign pc_ready     = (state == S_WAITPC);

endmodule

// File: tb/tb_ifu_fetch.sv
// Purpose:      self-checking bench for ifu_fetch; a table of fetch records plus reset corner sequences.
// Latency:      n/a (bench).
// Backpressure: bench drives arready/rvalid/out_ready delays from the table.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_arvalid;
    logic        imem_arready = 1'b0;
    logic [31:0] imem_araddr;
    logic        imem_rvalid = 1'b0;
    logic        imem_rready;
    logic [31:0] imem_rdata = 32'h0;
    logic [1:0]  imem_rresp = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic [31:0] pc_next = 32'h0;

    ifu_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_arvalid (imem_arvalid),
        .imem_arready (imem_arready),
        .imem_araddr  (imem_araddr),
        .imem_rvalid  (imem_rvalid),
        .imem_rready  (imem_rready),
        .imem_rdata   (imem_rdata),
        .imem_rresp   (imem_rresp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_fault    (out_fault),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .pc_next      (pc_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ar_dly;
        int          r_dly;
        int          out_dly;
        bit          noise;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_fault;
        logic [31:0] nxt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake outputs are mutually exclusive whenever the block is out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot_strobes",
                {31'd0, ($countones({imem_arvalid, imem_rready, out_valid, pc_ready}) <= 1)}, 32'd1);
        end
    end

    task automatic clear_noise();
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rresp   = 2'b00;
        imem_rdata   = 32'h0;
        out_ready    = 1'b0;
        pc_valid     = 1'b0;
        pc_next      = 32'h0;
    endtask

    // Strobes that belong to other states; the DUT must ignore them.
    task automatic set_noise(input bit en, input int phase);
        if (en) begin
            pc_valid = 1'b1;
            pc_next  = 32'hDEAD_BEE0;
            if (phase == 0) begin
                imem_rvalid = 1'b1; imem_rresp = 2'b10; imem_rdata = 32'hBAD0_BAD0; out_ready = 1'b1;
            end else if (phase == 1) begin
                imem_arready = 1'b1; out_ready = 1'b1;
            end else begin
                imem_arready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_arvalid"},   {31'd0, imem_arvalid}, 32'd1);
        chk({tag, "_araddr"},    imem_araddr, RESET_PC);
        chk({tag, "_rready"},    {31'd0, imem_rready}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'h0);
        chk({tag, "_out_pc"},    out_pc, RESET_PC);
        chk({tag, "_out_fault"}, {31'd0, out_fault}, 32'd0);
        chk({tag, "_pc_ready"},  {31'd0, pc_ready}, 32'd0);
    endtask

    function automatic vec_t mk(int ad, int rd, int od, bit nz, logic [1:0] resp, logic [31:0] rdata,
                                logic [31:0] epc, logic [31:0] ei, logic ef, logic [31:0] nxt);
        vec_t v;
        v.ar_dly = ad; v.r_dly = rd; v.out_dly = od; v.noise = nz;
        v.rresp = resp; v.rdata = rdata; v.exp_pc = epc;
        v.exp_instr = ei; v.exp_fault = ef; v.nxt = nxt;
        return v;
    endfunction

    // One instruction cycle: bus phase (unless the PC is misaligned), decode handshake, next PC.
    task automatic run_rec(input vec_t v);
        int   cyc;
        exp_t e;
        bit   bus;
        cyc = 0;
        bus = (v.exp_pc[1:0] == 2'b00);
        if (bus) begin
            chk("req_arvalid", {31'd0, imem_arvalid}, 32'd1);
            chk("req_araddr", imem_araddr, v.exp_pc);
            for (int i = 0; i < v.ar_dly; i++) begin
                set_noise(v.noise, 0);
                tick(); cyc++;
                clear_noise();
                chk("ar_hold_valid", {31'd0, imem_arvalid}, 32'd1);
                chk("ar_hold_addr", imem_araddr, v.exp_pc);
            end
            imem_arready = 1'b1;
            tick(); cyc++;
            imem_arready = 1'b0;
            for (int i = 0; i < v.r_dly; i++) begin
                chk("resp_rready", {31'd0, imem_rready}, 32'd1);
                set_noise(v.noise, 1);
                tick(); cyc++;
                clear_noise();
            end
            chk("resp_rready", {31'd0, imem_rready}, 32'd1);
            imem_rvalid = 1'b1;
            imem_rdata  = v.rdata;
            imem_rresp  = v.rresp;
            sb_q.push_back('{instr: v.exp_instr, pc: v.exp_pc, fault: v.exp_fault});
            tick(); cyc++;
            clear_noise();
        end else begin
            chk("misaligned_no_ar", {31'd0, imem_arvalid}, 32'd0);
            sb_q.push_back('{instr: v.exp_instr, pc: v.exp_pc, fault: v.exp_fault});
        end
        for (int k = 0; k < 16 && !out_valid; k++) begin
            tick(); cyc++;
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency", cyc, bus ? (2 + v.ar_dly + v.r_dly) : 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_instr", out_instr, e.instr);
            chk("out_pc", out_pc, e.pc);
            chk("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
            for (int i = 0; i < v.out_dly; i++) begin
                set_noise(v.noise, 2);
                tick();
                clear_noise();
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_instr", out_instr, e.instr);
                chk("stall_pc", out_pc, e.pc);
                chk("stall_pc_ready", {31'd0, pc_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("waitpc_ready", {31'd0, pc_ready}, 32'd1);
        chk("waitpc_out_valid", {31'd0, out_valid}, 32'd0);
        pc_valid = 1'b1;
        pc_next  = v.nxt;
        tick();
        clear_noise();
    endtask

    initial begin
        vecs[0] = mk(0, 0, 0, 0, 2'b00, 32'h0010_0093, 32'h8000_0000, 32'h0010_0093, 1'b0, 32'h8000_0004);
        vecs[1] = mk(3, 0, 5, 1, 2'b00, 32'h0020_0113, 32'h8000_0004, 32'h0020_0113, 1'b0, 32'h8000_0100);
        vecs[2] = mk(0, 2, 0, 1, 2'b00, 32'h1234_5678, 32'h8000_0100, 32'h1234_5678, 1'b0, 32'h8000_0102);
        vecs[3] = mk(0, 0, 2, 1, 2'b00, 32'h0,         32'h8000_0102, 32'h0000_0000, 1'b1, 32'h8000_0200);
        vecs[4] = mk(1, 1, 1, 0, 2'b10, 32'hFFFF_FFFF, 32'h8000_0200, 32'h0000_0000, 1'b1, 32'h8000_0204);
        vecs[5] = mk(0, 0, 0, 0, 2'b01, 32'h0000_0073, 32'h8000_0204, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
        vecs[6] = mk(0, 0, 0, 0, 2'b00, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0000_0000);
        vecs[7] = mk(2, 3, 1, 1, 2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h8000_0003);
        vecs[8] = mk(0, 0, 0, 0, 2'b00, 32'h0,         32'h8000_0003, 32'h0000_0000, 1'b1, 32'h8000_0300);

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        rst = 1'b0;
        check_reset_vals("rst_release");

        foreach (vecs[i]) run_rec(vecs[i]);

        // Asynchronous reset while a response is outstanding.
        chk("seqA_araddr", imem_araddr, 32'h8000_0300);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        chk("seqA_in_resp", {31'd0, imem_rready}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_mid_resp");
        tick();
        rst = 1'b0;
        // Late response from the abandoned transaction must be ignored in REQ.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("late_r_arvalid", {31'd0, imem_arvalid}, 32'd1);
            chk("late_r_rready", {31'd0, imem_rready}, 32'd0);
            chk("late_r_out_valid", {31'd0, out_valid}, 32'd0);
            chk("late_r_araddr", imem_araddr, RESET_PC);
        end
        clear_noise();
        run_rec(mk(0, 0, 0, 0, 2'b00, 32'h0010_0093, 32'h8000_0000, 32'h0010_0093, 1'b0, 32'h8000_0004));

        // Asynchronous reset while an instruction is waiting for decode.
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        imem_rvalid  = 1'b1;
        imem_rdata   = 32'hABCD_0013;
        tick();
        clear_noise();
        chk("seqB_out_valid", {31'd0, out_valid}, 32'd1);
        chk("seqB_out_instr", out_instr, 32'hABCD_0013);
        chk("seqB_out_pc", out_pc, 32'h8000_0004);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_mid_out");
        tick();
        rst = 1'b0;
        tick();
        chk("seqB_restart_addr", imem_araddr, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
